// File: rtl/usb_tx_pcu_if.sv
// usb_tx_pcu_if
//   Bundles the command, TX-buffer and serializer handshake signals of the
//   USB transmit packet control unit.
//   master : command source / TX buffer / serializer side (the environment)
//   slave  : the packet control unit itself
//   Signals:
//     tx_packet, tx_packet_data_size  packet command and payload size
//     tx_packet_data, get_tx_packet_data  TX buffer read port
//     tx_byte, load_byte, byte_done   byte handoff to the serializer
//     send_eop, eop_done              end-of-packet request/completion
//     tx_busy, tx_done, tx_error      status
interface usb_tx_pcu_if #(
  parameter int SIZE_W = 7
);
  logic [2:0]        tx_packet;
  logic [SIZE_W-1:0] tx_packet_data_size;
  logic [7:0]        tx_packet_data;
  logic              get_tx_packet_data;
  logic [7:0]        tx_byte;
  logic              load_byte;
  logic              byte_done;
  logic              send_eop;
  logic              eop_done;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_error;

  modport master (
    output tx_packet, tx_packet_data_size, tx_packet_data, byte_done, eop_done,
    input  get_tx_packet_data, tx_byte, load_byte, send_eop, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_packet, tx_packet_data_size, tx_packet_data, byte_done, eop_done,
    output get_tx_packet_data, tx_byte, load_byte, send_eop, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_pcu.sv
// usb_tx_pcu
//   Transmit-side packet control unit. On a one-cycle command in IDLE it
//   sequences SYNC, PID, optional payload (fetched from the TX buffer),
//   CRC16 and EOP, handing whole bytes to the serializer over load/done.
//   Ports:
//     clk    system clock, posedge
//     n_rst  asynchronous active-low reset
//     bus    usb_tx_pcu_if slave modport (command, TX buffer, serializer, status)
module usb_tx_pcu #(
  parameter int MAX_DATA = 64,
  parameter int SIZE_W   = 7
) (
  input logic          clk,
  input logic          n_rst,
  usb_tx_pcu_if.slave  bus
);

  localparam logic [2:0]        CMD_DATA0 = 3'd1;
  localparam logic [2:0]        CMD_DATA1 = 3'd2;
  localparam logic [2:0]        CMD_STALL = 3'd5;
  localparam logic [SIZE_W-1:0] MAX_SIZE  = SIZE_W'(MAX_DATA);

  typedef enum logic [3:0] {
    IDLE, SYNC_LD, SYNC_WT, PID_LD, PID_WT, FETCH, DATA_LD, DATA_WT,
    CRCL_LD, CRCL_WT, CRCH_LD, CRCH_WT, EOP, EOP_WT, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [15:0]       crc_q, crc_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              is_data_cmd;

  // PID byte is {~pid, pid}
  function automatic logic [7:0] pid_byte(input logic [2:0] cmd);
    logic [7:0] b;
    case (cmd)
      3'd1:    b = 8'hC3;
      3'd2:    b = 8'h4B;
      3'd3:    b = 8'hD2;
      3'd4:    b = 8'h5A;
      default: b = 8'h1E;
    endcase
    return b;
  endfunction

  // Reflected CRC16 (0xA001), one byte processed LSB first in a single cycle
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign is_data_cmd = (cmd_q == CMD_DATA0) || (cmd_q == CMD_DATA1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
      crc_q     <= 16'hFFFF;
      cnt_q     <= '0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
    end
  end

  // Next-byte values are prepared on the transition into each *_LD state so
  // the byte register already holds them for the whole load cycle.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_packet != 3'd0) begin
          if (bus.tx_packet > CMD_STALL) begin
            state_d = ERROR;
          end else if (((bus.tx_packet == CMD_DATA0) || (bus.tx_packet == CMD_DATA1)) &&
                       (bus.tx_packet_data_size > MAX_SIZE)) begin
            state_d = ERROR;
          end else begin
            cmd_d     = bus.tx_packet;
            cnt_d     = bus.tx_packet_data_size;
            crc_d     = 16'hFFFF;
            tx_byte_d = 8'h80;
            state_d   = SYNC_LD;
          end
        end
      end
      SYNC_LD: state_d = SYNC_WT;
      SYNC_WT: begin
        if (bus.byte_done) begin
          tx_byte_d = pid_byte(cmd_q);
          state_d   = PID_LD;
        end
      end
      PID_LD: state_d = PID_WT;
      PID_WT: begin
        if (bus.byte_done) begin
          if (!is_data_cmd) begin
            state_d = EOP;
          end else if (cnt_q != '0) begin
            state_d = FETCH;
          end else begin
            tx_byte_d = ~crc_q[7:0];
            state_d   = CRCL_LD;
          end
        end
      end
      FETCH: state_d = DATA_LD;
      DATA_LD: begin
        tx_byte_d = bus.tx_packet_data;
        crc_d     = crc_byte(crc_q, bus.tx_packet_data);
        cnt_d     = cnt_q - SIZE_W'(1);
        state_d   = DATA_WT;
      end
      DATA_WT: begin
        if (bus.byte_done) begin
          if (cnt_q != '0) begin
            state_d = FETCH;
          end else begin
            tx_byte_d = ~crc_q[7:0];
            state_d   = CRCL_LD;
          end
        end
      end
      CRCL_LD: state_d = CRCL_WT;
      CRCL_WT: begin
        if (bus.byte_done) begin
          tx_byte_d = ~crc_q[15:8];
          state_d   = CRCH_LD;
        end
      end
      CRCH_LD: state_d = CRCH_WT;
      CRCH_WT: if (bus.byte_done) state_d = EOP;
      EOP:     state_d = EOP_WT;
      EOP_WT:  if (bus.eop_done) state_d = DONE;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer data only arrives during DATA_LD, so that one load cycle presents
  // it directly; the register captures it and holds it until the next load.
  assign bus.tx_byte = (state_q == DATA_LD) ? bus.tx_packet_data : tx_byte_q;

  assign bus.load_byte = (state_q == SYNC_LD) || (state_q == PID_LD) || (state_q == DATA_LD) ||
                         (state_q == CRCL_LD) || (state_q == CRCH_LD);
  assign bus.get_tx_packet_data = (state_q == FETCH);
  assign bus.send_eop = (state_q == EOP);
  assign bus.tx_done  = (state_q == DONE);
  assign bus.tx_error = (state_q == ERROR);
  assign bus.tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_pcu.sv
// tb_usb_tx_pcu
//   Bench for usb_tx_pcu: a packet-level model predicts the byte stream and
//   the cycle of every strobe from the handshake latency rules; a serializer
//   model answers load_byte/send_eop, and a TX buffer model answers fetches.
module tb_usb_tx_pcu;
  localparam int MAX_DATA = 64;
  localparam int SIZE_W   = 7;

  typedef struct {
    logic [7:0] b;
    bit         d;
  } item_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_pcu_if #(.SIZE_W(SIZE_W)) bus ();

  usb_tx_pcu #(.MAX_DATA(MAX_DATA), .SIZE_W(SIZE_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] payload [0:127];
  item_t      exp_q [$];
  logic [7:0] log_q [$];
  bit active = 1'b0;
  int next_load = -1, next_fetch = -1, next_eop = -1, next_done = -1, next_err = -1;
  int bd_at = -1, eop_at = -1;
  int fetch_total = 0, eop_total = 0, done_total = 0, err_total = 0;
  int rd_idx = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // USB data CRC over a whole payload: bit stream LSB first, reflected poly
  function automatic logic [15:0] crc16_usb(input logic [7:0] data [$]);
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    foreach (data[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[0] ^ data[k][j];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    end
    return ~r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    active = 1'b0;
    next_load = -1; next_fetch = -1; next_eop = -1; next_done = -1; next_err = -1;
    bd_at = -1; eop_at = -1;
  endtask

  task automatic accept_cmd(input logic [2:0] c, input logic [SIZE_W-1:0] sz);
    logic [7:0] data [$];
    logic [15:0] crc;
    logic [7:0] pid;
    active = 1'b1;
    if (c >= 3'd6 || ((c == 3'd1 || c == 3'd2) && int'(sz) > MAX_DATA)) begin
      next_err = cyc;
      return;
    end
    case (c)
      3'd1:    pid = 8'hC3;
      3'd2:    pid = 8'h4B;
      3'd3:    pid = 8'hD2;
      3'd4:    pid = 8'h5A;
      default: pid = 8'h1E;
    endcase
    exp_q.delete();
    exp_q.push_back('{8'h80, 1'b0});
    exp_q.push_back('{pid, 1'b0});
    if (c == 3'd1 || c == 3'd2) begin
      for (int i = 0; i < int'(sz); i++) begin
        data.push_back(payload[i]);
        exp_q.push_back('{payload[i], 1'b1});
      end
      crc = crc16_usb(data);
      exp_q.push_back('{crc[7:0], 1'b0});
      exp_q.push_back('{crc[15:8], 1'b0});
    end
    next_load = cyc;
  endtask

  // TX buffer: byte appears the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.tx_busy !== 1'b1) begin
      rd_idx <= 0;
    end else if (bus.get_tx_packet_data) begin
      bus.tx_packet_data <= payload[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  // Compare process plus serializer model
  always @(negedge clk) begin
    if (!n_rst) begin
      model_clear();
      bus.byte_done = 1'b0;
      bus.eop_done  = 1'b0;
    end else if (bus.tx_packet != 3'd0 && !active) begin
      accept_cmd(bus.tx_packet, bus.tx_packet_data_size);
    end
    check("load_byte", bus.load_byte, cyc == next_load);
    check("get_tx_packet_data", bus.get_tx_packet_data, cyc == next_fetch);
    check("send_eop", bus.send_eop, cyc == next_eop);
    check("tx_done", bus.tx_done, cyc == next_done);
    check("tx_error", bus.tx_error, cyc == next_err);
    check("tx_busy", bus.tx_busy, active);
    if (bus.load_byte === 1'b1) begin
      log_q.push_back(bus.tx_byte);
      if (exp_q.size() > 0) begin
        check("tx_byte", bus.tx_byte, exp_q[0].b);
        void'(exp_q.pop_front());
      end
      bd_at = cyc + 8;
    end
    if (bus.get_tx_packet_data === 1'b1) fetch_total++;
    if (bus.send_eop === 1'b1) begin
      eop_total++;
      eop_at = cyc + 5;
    end
    if (bus.tx_done === 1'b1) done_total++;
    if (bus.tx_error === 1'b1) err_total++;
    if (cyc == next_done || cyc == next_err) active = 1'b0;
    if (n_rst) begin
      bus.byte_done = 1'b0;
      bus.eop_done  = 1'b0;
      if (cyc == bd_at) begin
        bus.byte_done = 1'b1;
        if (exp_q.size() == 0) begin
          next_eop = cyc + 1;
        end else if (exp_q[0].d) begin
          next_fetch = cyc + 1;
          next_load  = cyc + 2;
        end else begin
          next_load = cyc + 1;
        end
      end
      if (cyc == eop_at) begin
        bus.eop_done = 1'b1;
        next_done = cyc + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] c, input int sz);
    @(negedge clk);
    #2;
    bus.tx_packet = c;
    bus.tx_packet_data_size = SIZE_W'(sz);
    @(negedge clk);
    #2;
    bus.tx_packet = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("packet_timeout", active, 1'b0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int start, input logic [7:0] e [$], input int fetches, input int f0);
    check({name, "_byte_count"}, 16'(log_q.size() - start), 16'(e.size()));
    foreach (e[i]) begin
      if (start + i < log_q.size()) check({name, "_byte"}, log_q[start + i], e[i]);
    end
    check({name, "_fetches"}, 16'(fetch_total - f0), 16'(fetches));
  endtask

  initial begin
    logic [7:0] e [$];
    int ls, f0, d0, er0, ep0, n;
    bus.tx_packet = 3'd0;
    bus.tx_packet_data_size = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check("rst_tx_byte", bus.tx_byte, 8'h00);
    check("rst_tx_busy", bus.tx_busy, 1'b0);
    check("rst_load_byte", bus.load_byte, 1'b0);
    check("rst_send_eop", bus.send_eop, 1'b0);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;

    // ACK
    ls = log_q.size(); f0 = fetch_total; d0 = done_total; ep0 = eop_total;
    applyStimulus(3'd3, 0);
    wait_idle();
    e = '{8'h80, 8'hD2};
    checkOutput("ack", ls, e, 0, f0);
    check("ack_eops", 16'(eop_total - ep0), 16'd1);
    check("ack_done", 16'(done_total - d0), 16'd1);

    // DATA0, empty payload
    ls = log_q.size(); f0 = fetch_total;
    applyStimulus(3'd1, 0);
    wait_idle();
    e = '{8'h80, 8'hC3, 8'h00, 8'h00};
    checkOutput("data0_len0", ls, e, 0, f0);

    // DATA1, single zero byte
    payload[0] = 8'h00;
    ls = log_q.size(); f0 = fetch_total;
    applyStimulus(3'd2, 1);
    wait_idle();
    e = '{8'h80, 8'h4B, 8'h00, 8'h40, 8'hBF};
    checkOutput("data1_len1", ls, e, 1, f0);

    // DATA0 "123456789", with an ignored command issued mid-packet
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    ls = log_q.size(); f0 = fetch_total;
    applyStimulus(3'd1, 9);
    repeat (20) @(negedge clk);
    applyStimulus(3'd3, 0);
    wait_idle();
    e = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    checkOutput("data0_ascii", ls, e, 9, f0);

    // DATA1 with two arbitrary bytes, model-checked
    payload[0] = 8'hA5; payload[1] = 8'h3C;
    applyStimulus(3'd2, 2);
    wait_idle();

    // Oversized payload and invalid command
    ls = log_q.size(); er0 = err_total;
    applyStimulus(3'd1, MAX_DATA + 1);
    wait_idle();
    applyStimulus(3'd7, 0);
    wait_idle();
    check("err_pulses", 16'(err_total - er0), 16'd2);
    check("err_no_load", 16'(log_q.size() - ls), 16'd0);

    // Reset during DATA_WT of a maximum-size packet
    for (int i = 0; i < MAX_DATA; i++) payload[i] = 8'(i * 3 + 1);
    ls = log_q.size();
    applyStimulus(3'd1, MAX_DATA);
    n = 0;
    while (log_q.size() < ls + 10 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reset_wait_timeout", 16'(log_q.size() >= ls + 10), 16'd1);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_tx_busy", bus.tx_busy, 1'b0);
    check("midrst_load_byte", bus.load_byte, 1'b0);
    check("midrst_get", bus.get_tx_packet_data, 1'b0);
    check("midrst_tx_byte", bus.tx_byte, 8'h00);
    @(negedge clk);
    #2 n_rst = 1'b1;

    // NAK after the abort
    ls = log_q.size(); f0 = fetch_total;
    applyStimulus(3'd4, 0);
    wait_idle();
    e = '{8'h80, 8'h5A};
    checkOutput("nak", ls, e, 0, f0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb_tx_pcu.md
Name: usb_tx_pcu

Overview:
Packet control unit for the USB transmitter. It is the transmit-side counterpart of the receiver control unit. On a one-cycle packet command it sequences SYNC, PID, the optional data payload read from the endpoint TX buffer, CRC16 and EOP, in that order. It hands complete bytes to the downstream bit serializer/NRZI/bit-stuff stage over a load/done handshake and computes the data CRC16 on the fly.

Parameters:
MAX_DATA, 64, largest payload in bytes accepted for a DATA0/DATA1 packet
SIZE_W, 7, width of the payload size input; must satisfy 2^SIZE_W > MAX_DATA

Ports:
clk  input  1  system clock; all logic on posedge
n_rst  input  1  asynchronous active-low reset
tx_packet  input  3  command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 invalid; sampled only in IDLE
tx_packet_data_size  input  SIZE_W  payload byte count; sampled with tx_packet
tx_packet_data  input  8  byte from TX buffer, valid the cycle after get_tx_packet_data
get_tx_packet_data  output  1  one-cycle read strobe to TX buffer
tx_byte  output  8  byte to serializer; the serializer shifts it LSB first
load_byte  output  1  one-cycle strobe: tx_byte valid, serializer captures it
byte_done  input  1  pulse from serializer: last bit of current byte shifted out
send_eop  output  1  one-cycle strobe requesting EOP generation
eop_done  input  1  pulse from serializer: EOP and return to idle J complete
tx_busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse on successful completion
tx_error  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async, n_rst low): state IDLE. tx_byte=0x00. CRC reg=0xFFFF. Byte counter=0. All strobes and tx_busy/tx_done/tx_error=0. Reset mid-packet aborts immediately with no EOP; the serializer is reset by the same n_rst.
- States: IDLE, SYNC_LD, SYNC_WT, PID_LD, PID_WT, FETCH, DATA_LD, DATA_WT, CRCL_LD, CRCL_WT, CRCH_LD, CRCH_WT, EOP, EOP_WT, DONE, ERROR.
- IDLE:
  - tx_packet 1..5 -> SYNC_LD. Latch the command and size; counter=size; CRC=0xFFFF.
  - tx_packet 6/7, or data command with size>MAX_DATA -> ERROR.
  - tx_packet 0 -> stay in IDLE.
- Commands presented while not in IDLE are ignored (no queueing).
- Every *_LD state lasts exactly 1 cycle: load_byte=1 and tx_byte holds the byte. tx_byte is registered on entry, so it is stable for the whole LD cycle and until the next load.
- Every *_WT state holds until byte_done=1. A byte_done seen outside a *_WT state is ignored.
- SYNC byte is 0x80. SYNC_WT exits to PID_LD.
- PID byte is {~pid,pid}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- PID_WT exit:
  - handshake (ACK/NAK/STALL) -> EOP.
  - data packet with counter>0 -> FETCH.
  - data packet with counter=0 -> CRCL_LD.
- FETCH (1 cycle): get_tx_packet_data=1 -> DATA_LD.
- DATA_LD: tx_byte=tx_packet_data; CRC updated with that byte in the same cycle (8-bit unrolled); counter decremented.
- DATA_WT exit: counter>0 -> FETCH; counter=0 -> CRCL_LD.
- CRC16 definition: poly x^16+x^15+x^2+1, reflected form 0xA001. Init 0xFFFF, LSB-first. Transmitted value is ~CRC: low byte (CRCL) first, then high byte (CRCH).
- CRCL_WT exits to CRCH_LD; CRCH_WT exits to EOP.
- EOP (1 cycle): send_eop=1 -> EOP_WT. EOP_WT holds until eop_done -> DONE.
- DONE (1 cycle): tx_done=1 -> IDLE.
- ERROR (1 cycle): tx_error=1, nothing sent -> IDLE.
- Latency: command in IDLE at cycle N gives load_byte with 0x80 at N+1. byte_done in a WT state at cycle M gives the next load_byte at M+1, or M+2 when a FETCH comes first.
- Size 0 with DATA0/DATA1 is legal: no fetch; CRC bytes 0x00, 0x00. Size=MAX_DATA is legal; MAX_DATA+1 gives ERROR.
- byte_done and eop_done asserted in the same cycle: only the one the current state waits for is honoured.

Test Plan:
- ACK command, serializer returns byte_done 8 cycles after each load -> load_byte bytes 0x80, 0xD2; one send_eop; then tx_done after eop_done; get_tx_packet_data never asserted.
- DATA0 size 0 -> bytes 0x80, 0xC3, 0x00, 0x00, then EOP, then tx_done; no fetch strobes.
- DATA1 size 1, buffer byte 0x00 -> bytes 0x80, 0x4B, 0x00, 0x40, 0xBF; exactly one get_tx_packet_data.
- DATA0 size 9, buffer ASCII "123456789" (0x31..0x39) -> CRC bytes 0xC8, 0xB4 after the data; 9 fetch strobes.
- Size 65 with MAX_DATA=64, and command 7 -> each gives one tx_error pulse, no load_byte, IDLE next cycle; a second command issued while tx_busy=1 is ignored.
- n_rst pulsed low during DATA_WT of a 64-byte packet -> all outputs 0 immediately; a following NAK command transmits 0x80, 0x5A normally.
